// File: rtl/sync_seq_det_moore_pkg.sv
// Shared types and helpers for the sync_ckt sequence-detector slice.
package sync_ckt_pkg;

  localparam int SYM_W_DFLT = 2;
  localparam int CNT_W_DFLT = 8;

  typedef logic [SYM_W_DFLT-1:0] sym_t;

  localparam logic [CNT_W_DFLT-1:0] CNT_SAT_DFLT = '1;

  // Per-cycle control event, already resolved by priority.
  typedef enum logic [1:0] {
    EV_IDLE,
    EV_SYM,
    EV_LOAD,
    EV_CLR
  } ev_e;

  function automatic int state_w(input int seq_len);
    return $clog2(seq_len + 1);
  endfunction

endpackage

// File: rtl/sync_seq_det_moore_if.sv
// Symbol stream, pattern load and status bundle of the sequence detector.
interface sync_seq_det_moore_if
  import sync_ckt_pkg::*;
#(
  parameter int SYM_W   = 2,
  parameter int SEQ_LEN = 4,
  parameter int CNT_W   = 8
);
  localparam int ST_W = state_w(SEQ_LEN);

  logic                     clr;
  logic                     pat_load;
  logic [SEQ_LEN*SYM_W-1:0] pat_in;
  logic                     in_valid;
  logic [SYM_W-1:0]         in_sym;
  logic                     match;
  logic [ST_W-1:0]          state_o;
  logic [CNT_W-1:0]         match_cnt;

  modport master (
    output clr, pat_load, pat_in, in_valid, in_sym,
    input  match, state_o, match_cnt
  );

  modport slave (
    input  clr, pat_load, pat_in, in_valid, in_sym,
    output match, state_o, match_cnt
  );

endinterface

// File: rtl/sync_seq_prefix_cmp.sv
// Longest pattern prefix ending at the new symbol; hist[0] is the newest old symbol.
module sync_seq_prefix_cmp
  import sync_ckt_pkg::*;
#(
  parameter int SYM_W   = 2,
  parameter int SEQ_LEN = 4
) (
  input  logic [SEQ_LEN-2:0][SYM_W-1:0] hist,
  input  logic [SEQ_LEN-2:0]            hist_vld,
  input  logic [SYM_W-1:0]              sym,
  input  logic [SEQ_LEN-1:0][SYM_W-1:0] pat,
  output logic [state_w(SEQ_LEN)-1:0]   len
);
  localparam int ST_W = state_w(SEQ_LEN);

  logic [SEQ_LEN-1:0] hit;

  // Prefix k matches when the new symbol is pat[k-1] and the j-th older one is pat[k-1-j].
  for (genvar k = 1; k <= SEQ_LEN; k++) begin : g_pfx
    logic [k-1:0] eq;
    assign eq[0] = (sym == pat[k-1]);
    for (genvar j = 1; j < k; j++) begin : g_h
      assign eq[j] = hist_vld[j-1] && (hist[j-1] == pat[k-1-j]);
    end
    assign hit[k-1] = &eq;
  end

  always_comb begin
    len = '0;
    for (int k = 1; k <= SEQ_LEN; k++)
      if (hit[k-1]) len = ST_W'(k);
  end

endmodule

// File: rtl/sync_seq_det_moore.sv
// Moore detector for a loadable SEQ_LEN-symbol pattern with saturating match count.
// Optional idle timeout back to S0 is enabled by defining SYNC_SEQ_DET_TIMEOUT_EN.
module sync_seq_det_moore
  import sync_ckt_pkg::*;
#(
  parameter int SYM_W       = 2,
  parameter int SEQ_LEN     = 4,
  parameter int OVERLAP     = 1,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input logic            clk,
  input logic            rst_n,
  sync_seq_det_moore_if.slave bus
);
  localparam int              ST_W    = state_w(SEQ_LEN);
  localparam logic [ST_W-1:0] S_FULL  = ST_W'(SEQ_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  if (SYM_W < 1 || SEQ_LEN < 2 || SEQ_LEN > 16 || CNT_W < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("sync_seq_det_moore: illegal parameter set");
  end

  logic [SEQ_LEN-1:0][SYM_W-1:0] pat;
  logic [SEQ_LEN-2:0][SYM_W-1:0] hist, hist_n;
  logic [SEQ_LEN-2:0]            hist_vld, hist_vld_n, cmp_vld;
  logic [ST_W-1:0]               state, nxt_len;
  logic                          match;
  logic [CNT_W-1:0]              match_cnt;
  ev_e                           ev;

  always_comb begin
    ev = EV_IDLE;
    if      (bus.clr)      ev = EV_CLR;
    else if (bus.pat_load) ev = EV_LOAD;
    else if (bus.in_valid) ev = EV_SYM;
  end

  // Non-overlapping mode forgets everything once a full match has been seen.
  assign cmp_vld = (OVERLAP == 0 && state == S_FULL) ? '0 : hist_vld;

  always_comb begin
    hist_n        = hist;
    hist_vld_n    = cmp_vld;
    hist_n[0]     = bus.in_sym;
    hist_vld_n[0] = 1'b1;
    for (int i = 1; i < SEQ_LEN-1; i++) begin
      hist_n[i]     = hist[i-1];
      hist_vld_n[i] = cmp_vld[i-1];
    end
  end

  sync_seq_prefix_cmp #(.SYM_W(SYM_W), .SEQ_LEN(SEQ_LEN)) u_cmp (
    .hist     (hist),
    .hist_vld (cmp_vld),
    .sym      (bus.in_sym),
    .pat      (pat),
    .len      (nxt_len)
  );

`ifdef SYNC_SEQ_DET_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  logic [IDLE_W-1:0] idle_cnt;
  logic              idle_exp;

  assign idle_exp = (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           idle_cnt <= '0;
    else if (ev != EV_IDLE || state == '0) idle_cnt <= '0;
    else if (idle_exp)                    idle_cnt <= '0;
    else                                  idle_cnt <= idle_cnt + 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat       <= '0;
      hist      <= '0;
      hist_vld  <= '0;
      state     <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
    end else begin
      unique case (ev)
        EV_CLR: begin
          hist      <= '0;
          hist_vld  <= '0;
          state     <= '0;
          match     <= 1'b0;
          match_cnt <= '0;
        end
        EV_LOAD: begin
          pat      <= bus.pat_in;
          hist     <= '0;
          hist_vld <= '0;
          state    <= '0;
          match    <= 1'b0;
        end
        EV_SYM: begin
          hist     <= hist_n;
          hist_vld <= hist_vld_n;
          state    <= nxt_len;
          match    <= (nxt_len == S_FULL);
          if (nxt_len == S_FULL && match_cnt != CNT_SAT)
            match_cnt <= match_cnt + 1'b1;
        end
        default: begin
`ifdef SYNC_SEQ_DET_TIMEOUT_EN
          if (state != '0 && idle_exp) begin
            hist     <= '0;
            hist_vld <= '0;
            state    <= '0;
            match    <= 1'b0;
          end
`endif
        end
      endcase
    end
  end

  assign bus.state_o   = state;
  assign bus.match     = match;
  assign bus.match_cnt = match_cnt;

endmodule

// File: tb/tb_sync_seq_det_moore.sv
// Directed bench: an overlapping and a non-overlapping detector share one stimulus stream.
module tb_sync_seq_det_moore;
  import sync_ckt_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sync_seq_det_moore_if #(.SYM_W(2), .SEQ_LEN(4), .CNT_W(8)) b1 ();
  sync_seq_det_moore_if #(.SYM_W(2), .SEQ_LEN(4), .CNT_W(8)) b0 ();

  assign b0.clr      = b1.clr;
  assign b0.pat_load = b1.pat_load;
  assign b0.pat_in   = b1.pat_in;
  assign b0.in_valid = b1.in_valid;
  assign b0.in_sym   = b1.in_sym;

  sync_seq_det_moore #(.SYM_W(2), .SEQ_LEN(4), .OVERLAP(1), .CNT_W(8), .TIMEOUT_CYC(4)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));
  sync_seq_det_moore #(.SYM_W(2), .SEQ_LEN(4), .OVERLAP(0), .CNT_W(8), .TIMEOUT_CYC(4)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave));

`ifdef SYNC_SEQ_DET_TIMEOUT_EN
  localparam int GAP_CNT = 1;
  localparam int GAP_ST  = 0;
`else
  localparam int GAP_CNT = 2;
  localparam int GAP_ST  = 2;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input sym_t s);
    b1.in_valid = 1'b1;
    b1.in_sym   = s;
    tick();
    b1.in_valid = 1'b0;
  endtask

  task automatic load(input logic [7:0] p);
    b1.pat_load = 1'b1;
    b1.pat_in   = p;
    tick();
    b1.pat_load = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    b1.clr      = 1'b0;
    b1.pat_load = 1'b0;
    b1.pat_in   = '0;
    b1.in_valid = 1'b0;
    b1.in_sym   = '0;
    tick(); tick();
    chk("rst_state", 32'(b1.state_o), 0);
    chk("rst_match", 32'(b1.match), 0);
    chk("rst_cnt", 32'(b1.match_cnt), 0);
    rst_n = 1'b1;

    // Pattern {0,1,2,3}: straight match
    load(8'hE4);
    chk("load_state", 32'(b1.state_o), 0);
    send(2'd0); chk("p0123_s1", 32'(b1.state_o), 1);
    send(2'd1); chk("p0123_s2", 32'(b1.state_o), 2);
    send(2'd2); chk("p0123_s3", 32'(b1.state_o), 3);
    chk("p0123_nomatch", 32'(b1.match), 0);
    send(2'd3);
    chk("p0123_match", 32'(b1.match), 1);
    chk("p0123_s4", 32'(b1.state_o), 4);
    chk("p0123_cnt", 32'(b1.match_cnt), 1);
    chk("p0123_cnt_ov0", 32'(b0.match_cnt), 1);
    tick();
    chk("match_hold_idle", 32'(b1.match), 1);

    // Gap of idle cycles between accepted symbols
    send(2'd0); send(2'd1);
    chk("gap_pre", 32'(b1.state_o), 2);
    repeat (4) tick();
    chk("gap_4idle", 32'(b1.state_o), GAP_ST);
    tick();
    chk("gap_5idle", 32'(b1.state_o), GAP_ST);
    send(2'd2); send(2'd3);
    chk("gap_match", 32'(b1.match), (GAP_CNT == 2) ? 1 : 0);
    chk("gap_cnt", 32'(b1.match_cnt), GAP_CNT);

    // pat_load with in_valid: symbol dropped
    b1.in_valid = 1'b1;
    b1.in_sym   = 2'd1;
    load(8'h55);
    chk("ld_prio_state", 32'(b1.state_o), 0);
    chk("ld_prio_match", 32'(b1.match), 0);
    chk("ld_keeps_cnt", 32'(b1.match_cnt), GAP_CNT);
    send(2'd1); send(2'd1); send(2'd1);
    chk("ld_drop_sym", 32'(b1.state_o), 3);
    send(2'd1); send(2'd1); send(2'd1); send(2'd1);
    chk("ones_ov1_cnt", 32'(b1.match_cnt), GAP_CNT + 4);
    chk("ones_ov0_cnt", 32'(b0.match_cnt), GAP_CNT + 1);
    chk("ones_ov0_state", 32'(b0.state_o), 3);
    chk("ones_ov1_match", 32'(b1.match), 1);

    // clr with in_valid while matched
    b1.clr      = 1'b1;
    b1.in_valid = 1'b1;
    b1.in_sym   = 2'd1;
    tick();
    b1.clr      = 1'b0;
    b1.in_valid = 1'b0;
    chk("clr_match", 32'(b1.match), 0);
    chk("clr_cnt", 32'(b1.match_cnt), 0);
    chk("clr_state", 32'(b1.state_o), 0);
    send(2'd1); send(2'd1); send(2'd1);
    chk("clr_drop_sym", 32'(b1.state_o), 3);
    send(2'd1);
    chk("clr_keeps_pat", 32'(b1.match_cnt), 1);

    // Self-overlapping pattern {0,0,1,0}
    load(8'h10);
    send(2'd0); chk("ovl_s1", 32'(b1.state_o), 1);
    send(2'd0); chk("ovl_s2", 32'(b1.state_o), 2);
    send(2'd0); chk("ovl_s2b", 32'(b1.state_o), 2);
    send(2'd1); chk("ovl_s3", 32'(b1.state_o), 3);
    send(2'd0); chk("ovl_s4", 32'(b1.state_o), 4);
    chk("ovl_match", 32'(b1.match), 1);
    chk("ovl_cnt", 32'(b1.match_cnt), 2);
    chk("ovl_cnt_ov0", 32'(b0.match_cnt), 2);

    // Counter saturation
    b1.clr = 1'b1; tick(); b1.clr = 1'b0;
    load(8'h55);
    repeat (300) send(2'd1);
    chk("sat_cnt", 32'(b1.match_cnt), 255);
    chk("sat_match", 32'(b1.match), 1);
    chk("sat_cnt_ov0", 32'(b0.match_cnt), 75);

    // Asynchronous reset mid-sequence
    send(2'd0); send(2'd1); send(2'd1);
    chk("pre_rst_state", 32'(b1.state_o), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(b1.state_o), 0);
    chk("arst_cnt", 32'(b1.match_cnt), 0);
    chk("arst_match", 32'(b1.match), 0);
    #1 rst_n = 1'b1;
    send(2'd0); send(2'd0); send(2'd0); send(2'd0);
    chk("arst_pat_zero", 32'(b1.match_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_seq_det_moore.md
Name: sync_seq_det_moore

Overview:
Parametrised Moore sequence detector. It watches a W-bit symbol stream that is qualified by a valid strobe, and flags each occurrence of a runtime-loadable pattern of SEQ_LEN symbols. It generalises the fixed 4-state Moore FSM in sync_ckt in four ways: symbol width, pattern length, overlap mode and a match counter. It sits in sync_ckt as a reusable protocol/preamble detector.

Parameters:
SYM_W, 2, symbol width in bits (>=1)
SEQ_LEN, 4, pattern length in symbols (2..16)
OVERLAP, 1, 1 = overlapping matches allowed; 0 = detection restarts from empty after a match
CNT_W, 8, match counter width
TIMEOUT_CYC, 16, idle timeout in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
clr  in  1  synchronous clear of state, history and counter
pat_load  in  1  load pattern strobe
pat_in  in  SEQ_LEN*SYM_W  pattern; symbol 0 (first expected) in bits [SYM_W-1:0]
in_valid  in  1  in_sym is valid this cycle
in_sym  in  SYM_W  input symbol
match  out  1  Moore output; high while state == SEQ_LEN
state_o  out  $clog2(SEQ_LEN+1)  current state, i.e. matched prefix length
match_cnt  out  CNT_W  saturating count of matches

Behaviour:
- Reset (rst_n low, async): state=0, history cleared, pattern register=0, match=0, state_o=0, match_cnt=0.
- States S0..S_SEQ_LEN. State k means the last k accepted symbols equal pattern symbols 0..k-1.
- State advances only on cycles with in_valid=1. Otherwise state holds and match holds.
- Next state on an accepted symbol = the largest k (0..SEQ_LEN) such that the last k accepted symbols, including the new one, equal pattern[0..k-1].
  - Use a history shift register of SEQ_LEN-1 symbols plus the new symbol, with a parallel compare against every prefix.
  - This gives correct fallback for self-overlapping patterns (KMP-equivalent).
- OVERLAP=0: on the symbol accepted while in S_SEQ_LEN, the history is treated as empty. Next state = 1 if sym==pattern[0], else 0.
- OVERLAP=1: normal rule. S_SEQ_LEN can be re-entered directly, e.g. pattern AAAA with input A held.
- Outputs:
  - match is a function of the registered state only.
  - Latency: match rises the cycle after the final pattern symbol is accepted, and stays high until the next accepted symbol.
- match_cnt increments by 1 on every clock edge that enters S_SEQ_LEN, including re-entry from S_SEQ_LEN. It saturates at all-ones.
- pat_load=1: the pattern register takes pat_in; state=0 and history are cleared; match_cnt is kept.
- Simultaneous events, in priority order:
  - clr beats pat_load.
  - pat_load beats in_valid; the symbol is dropped.
  - clr with in_valid: the symbol is dropped.
- clr: state=0, history cleared, match_cnt=0; the pattern is kept.
- Reset mid-sequence: immediate return to S0 and all outputs to their reset values. The pattern must be reloaded after reset.

Optional Feature:
SYNC_SEQ_DET_TIMEOUT_EN.
- Defined: an idle counter counts cycles with in_valid=0 while state!=0, and resets on any accepted symbol. When it reaches TIMEOUT_CYC, state returns to S0 and history clears on the next edge; match_cnt is unaffected. clr and pat_load also reset the counter.
- Undefined: no idle counter; state holds indefinitely without in_valid.

Decomposition:
- Package sync_ckt_pkg:
  - function clog2-based state width helper
  - typedef for symbol
  - localparam for counter all-ones saturation
- One sub-module, sync_seq_prefix_cmp: purely combinational. Inputs are the history, the new symbol and the pattern; output is the longest-matching-prefix length.
- The FSM, history, counter and timeout stay in the top module.

Test Plan:
- Reset then pat_load pattern {0,1,2,3} (SYM_W=2), stream 0,1,2,3 one symbol per cycle -> match=1 the cycle after 3, match_cnt=1, state_o=4.
- Pattern {1,1,1,1}, stream seven 1s:
  - OVERLAP=1 -> match_cnt=4.
  - OVERLAP=0 -> match_cnt=1.
- Self-overlap fallback, pattern {0,0,1,0}, stream 0,0,0,1,0 -> state_o sequence 1,2,2,3,4, then match=1.
- in_valid gaps: pattern {0,1,2,3}, stream 0,1, idle 5 cycles, 2,3 -> match=1 at the end (timeout macro off); state_o holds at 2 during the gap.
- Priority: pat_load and in_valid together -> state_o=0 and the symbol ignored. clr with match=1 -> match=0, match_cnt=0 next cycle. Drive 255+ matches with CNT_W=8 -> match_cnt stays 255.
- With SYNC_SEQ_DET_TIMEOUT_EN and TIMEOUT_CYC=4: accept 0,1, then idle 4 cycles -> state_o=0; then 2,3 -> no match.
